// File: rtl/multicycle_shifter_pkg.sv
// Shared encodings for the shifter and the ALU that feeds it:
// FSM states and the la/lr operand-select constants.
package multicycle_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // la: shift kind
    localparam logic LOGIC = 1'b0;
    localparam logic ARITH = 1'b1;

    // lr: shift direction
    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    // Bit shifted into the vacated position. Only an arithmetic right shift
    // replicates the sign; every other combination fills with zero.
    function automatic logic fill_bit(input logic la, input logic lr, input logic sign);
        return (la == ARITH && lr == RIGHT) ? sign : 1'b0;
    endfunction

endpackage

// File: rtl/multicycle_shifter_shift_step.sv
// One-position shifter. Purely combinational; the top module applies it
// once per cycle to walk the working register toward the final result.
module shift_step
    import multicycle_shifter_pkg::*;
#(
    parameter int BITWIDTH = 32
) (
    input  logic [BITWIDTH-1:0] operand,
    input  logic                la,
    input  logic                lr,
    input  logic                sign,
    output logic [BITWIDTH-1:0] shifted
);

    logic fill;

    // Shift by exactly one bit in the requested direction with the proper fill.
    always_comb begin
        fill    = fill_bit(la, lr, sign);
        shifted = '0;
        if (lr == RIGHT) begin
            shifted = {fill, operand[BITWIDTH-1:1]};
        end else begin
            shifted = {operand[BITWIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/multicycle_shifter.sv
// Multicycle barrel-shifter replacement: shifts one bit per clock, so an
// N-position shift completes N+1 cycles after the request is accepted.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE with flush low; out_valid is high
// only in DONE and, once high, result and out_valid hold until out_ready.
// flush beats both handshakes on the same edge.
module multicycle_shifter
    import multicycle_shifter_pkg::*;
#(
    parameter int BITWIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BITWIDTH-1:0]         data,
    input  logic                        la,
    input  logic                        lr,
    input  logic [$clog2(BITWIDTH)-1:0] shift_number,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BITWIDTH-1:0]         result,
    output logic                        busy,
    output logic [1:0]                  dbg_state
);

    localparam int SW = $clog2(BITWIDTH);
    localparam logic [SW-1:0] CNT_ONE = SW'(1);

    state_t state;
    state_t state_next;

    logic [BITWIDTH-1:0] work;
    logic [BITWIDTH-1:0] work_step;
    logic [SW-1:0]       count;
    logic                la_q;
    logic                lr_q;
    logic                sign_q;
    logic                accept;

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == IDLE) && !flush;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = work;
    assign dbg_state = state;

    // Single-bit step driven from the captured operand controls, never the live inputs.
    shift_step #(
        .BITWIDTH (BITWIDTH)
    ) u_shift_step (
        .operand (work),
        .la      (la_q),
        .lr      (lr_q),
        .sign    (sign_q),
        .shifted (work_step)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (shift_number == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (count == CNT_ONE) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // Operand capture, working register and remaining-shift counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work   <= '0;
            count  <= '0;
            la_q   <= LOGIC;
            lr_q   <= LEFT;
            sign_q <= 1'b0;
        end else if (flush) begin
            count <= '0;
        end else if (accept) begin
            work   <= data;
            count  <= shift_number;
            la_q   <= la;
            lr_q   <= lr;
            sign_q <= data[BITWIDTH-1];
        end else if (state == SHIFT) begin
            work  <= work_step;
            count <= count - CNT_ONE;
        end
    end

endmodule
